// File: rtl/port_rd_scheduler.sv
// rtl/port_rd_scheduler.sv - per-port read scheduler: strict-priority / WRR queue arbitration
// Grants one queue at a time to the read engine and holds the request until it is acknowledged.
module port_rd_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrr_en,
  input  logic [31:0] wrr_weight,
  input  logic [7:0]  queue_nonempty,
  input  logic        ready,
  output logic        sched_vld,
  output logic [2:0]  sched_queue,
  input  logic        sched_ack,
  input  logic        pkt_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ARB, REQ, XFER} state_t;

  state_t     state, state_nxt;
  logic [3:0] credit [8];
  logic [3:0] reload_val [8];
  logic [3:0] eff_credit [8];
  logic [2:0] ptr;
  logic       mode_wrr;
  logic [7:0] eligible_raw;
  logic [7:0] eligible;
  logic       need_reload;
  logic       wrr_found;
  logic [2:0] wrr_sel;
  logic [2:0] strict_sel;
  logic [2:0] idx;
  logic       any_nonempty;
  logic       hs;

  assign any_nonempty = |queue_nonempty;
  assign hs           = (state == REQ) && sched_vld && sched_ack;

  // A weight of zero still earns one grant per round so no queue starves.
  always_comb begin
    for (int q = 0; q < 8; q++) begin
      reload_val[q]   = (wrr_weight[4*q +: 4] == 4'd0) ? 4'd1 : wrr_weight[4*q +: 4];
      eligible_raw[q] = queue_nonempty[q] && (credit[q] != 4'd0);
    end
    need_reload = ~|eligible_raw;
    for (int q = 0; q < 8; q++) begin
      eff_credit[q] = need_reload ? reload_val[q] : credit[q];
      eligible[q]   = queue_nonempty[q] && (eff_credit[q] != 4'd0);
    end
  end

  always_comb begin
    wrr_sel   = ptr;
    wrr_found = 1'b0;
    idx       = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!wrr_found && eligible[idx]) begin
        wrr_sel   = idx;
        wrr_found = 1'b1;
      end
    end
  end

  always_comb begin
    strict_sel = 3'd0;
    for (int q = 0; q < 8; q++) begin
      if (queue_nonempty[q]) strict_sel = 3'(q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (ready && any_nonempty) state_nxt = ARB;
      ARB:  state_nxt = any_nonempty ? REQ : IDLE;
      REQ:  if (hs) state_nxt = XFER;
      XFER: if (pkt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mode is latched in ARB so the handshake credit update follows the mode that made the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sched_vld   <= 1'b0;
      sched_queue <= 3'd0;
      ptr         <= 3'd0;
      mode_wrr    <= 1'b0;
      for (int q = 0; q < 8; q++) credit[q] <= 4'd0;
    end else begin
      case (state)
        ARB: begin
          if (any_nonempty) begin
            sched_vld <= 1'b1;
            mode_wrr  <= wrr_en;
            if (wrr_en) begin
              sched_queue <= wrr_sel;
              if (need_reload) begin
                for (int q = 0; q < 8; q++) credit[q] <= reload_val[q];
              end
            end else begin
              sched_queue <= strict_sel;
            end
          end
        end
        REQ: begin
          if (hs) begin
            sched_vld <= 1'b0;
            if (mode_wrr && (credit[sched_queue] != 4'd0)) begin
              credit[sched_queue] <= credit[sched_queue] - 4'd1;
              if (credit[sched_queue] == 4'd1) ptr <= sched_queue + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_port_rd_scheduler.sv
// tb/tb_port_rd_scheduler.sv - scoreboard bench for port_rd_scheduler
module tb_port_rd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrr_en;
  logic [31:0] wrr_weight;
  logic [7:0]  queue_nonempty;
  logic        ready;
  logic        sched_vld;
  logic [2:0]  sched_queue;
  logic        sched_ack;
  logic        pkt_done;
  logic        busy;

  always #5 clk = ~clk;

  port_rd_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wrr_en         (wrr_en),
    .wrr_weight     (wrr_weight),
    .queue_nonempty (queue_nonempty),
    .ready          (ready),
    .sched_vld      (sched_vld),
    .sched_queue    (sched_queue),
    .sched_ack      (sched_ack),
    .pkt_done       (pkt_done),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  logic [3:0] m_credit [8];
  logic [2:0] m_ptr;
  logic       m_mode;
  int         m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 8; q++) m_credit[q] = 4'd0;
    m_ptr  = 3'd0;
    m_mode = 1'b0;
    m_last = 0;
  endtask

  task automatic model_pick(input logic [7:0] ne, input logic wrr, input logic [31:0] w, output int q);
    bit any;
    int i;
    q = -1;
    m_mode = wrr;
    if (!wrr) begin
      for (i = 7; i >= 0 && q < 0; i--) if (ne[i]) q = i;
    end else begin
      any = 0;
      for (i = 0; i < 8; i++) if (ne[i] && m_credit[i] != 0) any = 1;
      if (!any)
        for (i = 0; i < 8; i++) m_credit[i] = (w[4*i +: 4] == 0) ? 4'd1 : w[4*i +: 4];
      for (i = 0; i < 8 && q < 0; i++)
        if (ne[(m_ptr + i) % 8] && m_credit[(m_ptr + i) % 8] != 0) q = (m_ptr + i) % 8;
    end
    m_last = q;
  endtask

  task automatic model_ack();
    if (m_mode && m_credit[m_last] != 0) begin
      m_credit[m_last] = m_credit[m_last] - 4'd1;
      if (m_credit[m_last] == 0) m_ptr = 3'((m_last + 1) % 8);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wrr_en = 1'b0; wrr_weight = '0; queue_nonempty = '0;
    ready = 1'b0; sched_ack = 1'b0; pkt_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  // Waits for a request, compares it with the scoreboard, optionally stalls, then completes it.
  task automatic serve(input int stall, input bit scramble);
    int n = 0;
    int exp;
    logic [2:0] held;
    while (!sched_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sched_vld) begin
      check("vld_timeout", 32'(sched_vld), 32'd1);
      return;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check("grant", 32'(sched_queue), 32'(exp));
    held = sched_queue;
    for (int i = 0; i < stall; i++) begin
      if (scramble) begin
        wrr_en         = 1'($urandom);
        wrr_weight     = $urandom;
        queue_nonempty = 8'($urandom);
      end
      @(negedge clk);
      check("stall_vld", 32'(sched_vld), 32'd1);
      check("stall_queue", 32'(sched_queue), 32'(held));
    end
    sched_ack = 1'b1;
    @(negedge clk);
    sched_ack = 1'b0;
    model_ack();
    check("ack_clears_vld", 32'(sched_vld), 32'd0);
    check("xfer_busy", 32'(busy), 32'd1);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    check("done_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q;
    logic [7:0] ne;

    do_reset();
    check("reset_vld", 32'(sched_vld), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_queue", 32'(sched_queue), 32'd0);

    // Reset out of XFER, then two-edge request latency.
    queue_nonempty = 8'h04; ready = 1'b1;
    @(negedge clk);
    check("lat_edge1_vld", 32'(sched_vld), 32'd0);
    @(negedge clk);
    check("lat_edge2_vld", 32'(sched_vld), 32'd1);
    check("lat_queue", 32'(sched_queue), 32'd2);
    sched_ack = 1'b1;
    @(negedge clk);
    sched_ack = 1'b0;
    check("in_xfer_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; queue_nonempty = 8'h00;
    repeat (2) @(negedge clk);
    check("xfer_rst_vld", 32'(sched_vld), 32'd0);
    check("xfer_rst_busy", 32'(busy), 32'd0);
    check("xfer_rst_queue", 32'(sched_queue), 32'd0);
    rst_n = 1'b1; queue_nonempty = 8'h01; ready = 1'b1;
    @(negedge clk);
    check("post_rst_edge1_vld", 32'(sched_vld), 32'd0);
    @(negedge clk);
    check("post_rst_edge2_vld", 32'(sched_vld), 32'd1);
    check("post_rst_queue", 32'(sched_queue), 32'd0);

    // Strict priority.
    do_reset();
    wrr_en = 1'b0; queue_nonempty = 8'b0010_0101; ready = 1'b1;
    repeat (3) exp_q.push_back(5);
    repeat (3) serve(0, 0);

    // WRR sequence with a stall on the third grant.
    do_reset();
    wrr_en = 1'b1; wrr_weight = 32'h0000_0012; queue_nonempty = 8'b0000_0011; ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    for (int i = 0; i < 6; i++) serve((i == 2) ? 5 : 0, 0);

    // Vanishing queue.
    do_reset();
    queue_nonempty = 8'h10; ready = 1'b1;
    @(negedge clk);
    check("arb_busy", 32'(busy), 32'd1);
    queue_nonempty = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("vanish_vld", 32'(sched_vld), 32'd0);
    end
    check("vanish_idle", 32'(busy), 32'd0);

    // Ready gating.
    do_reset();
    queue_nonempty = 8'hFF; ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ready_gate_busy", 32'(busy), 32'd0);
    end

    // Random mix of modes and weights, with input churn while requests are stalled.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      wrr_en         = ($urandom_range(0, 3) != 0);
      wrr_weight     = $urandom;
      if ($urandom_range(0, 2) == 0) wrr_weight[7:0] = 8'h00;
      ne             = 8'($urandom_range(1, 255));
      queue_nonempty = ne;
      ready          = 1'b1;
      model_pick(ne, wrr_en, wrr_weight, q);
      exp_q.push_back(q);
      serve($urandom_range(0, 3), 1);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
